// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-drive bundle between two requesters, the arbiter and the shared ALU.
interface alu_arbiter_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [1:0][WIDTH-1:0]       req_a;
    logic [1:0][WIDTH-1:0]       req_b;
    logic [1:0][2:0]             req_sel;
    logic [1:0]                  rsp_valid;
    logic [WIDTH-1:0]            rsp_data;
    logic                        busy;
    logic [WIDTH-1:0]            alu_data1;
    logic [WIDTH-1:0]            alu_data2;
    logic [2:0]                  alu_select;
    logic [WIDTH-1:0]            alu_result;
    logic [1:0][CNT_W-1:0]       gnt_cnt;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, alu_result,
        output req_ready, rsp_valid, rsp_data, busy, alu_data1, alu_data2, alu_select, gnt_cnt
    );
    modport master (
        output req_valid, req_a, req_b, req_sel, alu_result,
        input  req_ready, rsp_valid, rsp_data, busy, alu_data1, alu_data2, alu_select, gnt_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 8-bit ALU between two requesters, one operation at a time.
// Optional per-requester saturating grant counters under ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_arbiter_if.slave  bus
);
    localparam int EW = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CW = $clog2(EW + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q;
    logic             last_q;
    logic             owner_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] data1_q, data2_q, rsp_data_q;
    logic [2:0]       sel_q;
    logic [1:0]       rsp_valid_q;
    logic             busy_q;

    logic [1:0] gnt;
    logic       gnt_idx;
    logic [2:0] sel_in;

    // Ready is gated by reset so every output reads 0 while RESET is held.
    always_comb begin
        gnt = 2'b00;
        if (state_q == IDLE && !rst_i) begin
            case (bus.req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt_idx = gnt[1];
    assign sel_in  = bus.req_sel[gnt_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            sel_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    data1_q <= bus.req_a[gnt_idx];
                    data2_q <= bus.req_b[gnt_idx];
                    // Reserved selects collapse to FORWARD so the response is operand B.
                    sel_q   <= sel_in[2] ? 3'b000 : sel_in;
                    owner_q <= gnt_idx;
                    cnt_q   <= CW'(EW);
                    busy_q  <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: if (cnt_q == CW'(1)) begin
                    rsp_data_q  <= bus.alu_result;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                RESP: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    last_q      <= owner_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = busy_q;
    assign bus.alu_data1  = data1_q;
    assign bus.alu_data2  = data2_q;
    assign bus.alu_select = sel_q;

`ifdef ALU_ARB_STATS_EN
    for (genvar i = 0; i < 2; i++) begin : g_cnt
        logic [CNT_W-1:0] gcnt_q, gcnt_d;
        always_comb begin
            gcnt_d = gcnt_q;
            if (gnt[i] && !(&gcnt_q)) gcnt_d = gcnt_q + 1'b1;
        end
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) gcnt_q <= '0;
            else       gcnt_q <= gcnt_d;
        end
        assign bus.gnt_cnt[i] = gcnt_q;
    end
`else
    assign bus.gnt_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;
    parameter int W = 1;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        int         owner;
        logic [7:0] data;
        int         due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    alu_arbiter #(.WIDTH(WIDTH), .WAIT_CYCLES(W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    function automatic logic [7:0] ref_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return b;
        endcase
    endfunction

    // The ALU itself: combinational over its DATA1/DATA2/SELECT inputs.
    assign bus.alu_result = ref_op(bus.alu_select, bus.alu_data1, bus.alu_data2);

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    rsp_t       q[$];
    int         free_at = 0;
    int         acc_edge = -1;
    logic       m_last = 1'b1;
    int         m_cnt[2] = '{0, 0};
    logic [7:0] exp_d1 = '0, exp_d2 = '0, pend_d1, pend_d2;
    logic [2:0] exp_sel = '0, pend_sel;

    always @(negedge clk) begin : model
        logic [1:0]  er;
        logic [15:0] ecnt;
        int          idx;
        rsp_t        it;
        if (!rst) begin
            if (cyc == acc_edge) begin
                exp_d1 = pend_d1; exp_d2 = pend_d2; exp_sel = pend_sel;
            end
            chk("alu_data1", bus.alu_data1, exp_d1);
            chk("alu_data2", bus.alu_data2, exp_d2);
            chk("alu_select", bus.alu_select, exp_sel);
            chk("busy", bus.busy, cyc < free_at);
`ifdef ALU_ARB_STATS_EN
            ecnt = {m_cnt[1][7:0], m_cnt[0][7:0]};
`else
            ecnt = 16'h0;
`endif
            chk("gnt_cnt", bus.gnt_cnt, ecnt);
            er = 2'b00;
            if (cyc >= free_at) begin
                if (bus.req_valid == 2'b01)      er = 2'b01;
                else if (bus.req_valid == 2'b10) er = 2'b10;
                else if (bus.req_valid == 2'b11) er = m_last ? 2'b01 : 2'b10;
            end
            chk("req_ready", bus.req_ready, er);
            if (er != 2'b00) begin
                idx      = er[1] ? 1 : 0;
                pend_d1  = bus.req_a[idx];
                pend_d2  = bus.req_b[idx];
                pend_sel = bus.req_sel[idx][2] ? 3'b000 : bus.req_sel[idx];
                it.owner = idx;
                it.data  = ref_op(pend_sel, pend_d1, pend_d2);
                it.due   = cyc + 1 + W;
                q.push_back(it);
                acc_edge = cyc + 1;
                free_at  = cyc + W + 2;
                m_last   = er[1];
                if (m_cnt[idx] < CMAX) m_cnt[idx]++;
            end
        end
    end

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!rst) begin
            if (bus.rsp_valid != 2'b00) begin
                if (q.size() == 0) chk("rsp_spurious", bus.rsp_valid, 2'b00);
                else begin
                    e = q.pop_front();
                    chk("rsp_owner", bus.rsp_valid, (e.owner == 1) ? 2'b10 : 2'b01);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_time", cyc, e.due);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rsp_missing", bus.rsp_valid, (q[0].owner == 1) ? 2'b10 : 2'b01);
                void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] s0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] s1);
        bus.req_valid = v;
        bus.req_a[0] = a0; bus.req_b[0] = b0; bus.req_sel[0] = s0;
        bus.req_a[1] = a1; bus.req_b[1] = b1; bus.req_sel[1] = s1;
    endtask

    task automatic idle_cycles(input int n);
        drive(2'b00, 8'h0, 8'h0, 3'd0, 8'h0, 8'h0, 3'd0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 2'b00);
        chk({tag, "_rsp_data"}, bus.rsp_data, 8'h00);
        chk({tag, "_alu_d1"}, bus.alu_data1, 8'h00);
        chk({tag, "_alu_d2"}, bus.alu_data2, 8'h00);
        chk({tag, "_alu_sel"}, bus.alu_select, 3'b000);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_ready"}, bus.req_ready, 2'b00);
        chk({tag, "_gnt_cnt"}, bus.gnt_cnt, 16'h0);
    endtask

    initial begin
        drive(2'b11, 8'h0, 8'h0, 3'd0, 8'h0, 8'h0, 3'd0);
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        drive(2'b00, 8'h0, 8'h0, 3'd0, 8'h0, 8'h0, 3'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle_cycles(2);

        // ADD from requester 0
        drive(2'b01, 8'h05, 8'h03, 3'b001, 8'h0, 8'h0, 3'd0);
        @(posedge clk); #1 idle_cycles(W + 3);

        // Reserved select from requester 1 forwards B
        drive(2'b10, 8'h0, 8'h0, 3'd0, 8'h77, 8'hAA, 3'b101);
        @(posedge clk); #1 idle_cycles(W + 3);

        // Both held: strict alternation AND / OR
        drive(2'b11, 8'hF0, 8'h3C, 3'b010, 8'hF0, 8'h3C, 3'b011);
        repeat (4 * (W + 2)) @(posedge clk);
        #1 idle_cycles(W + 3);

        // Req1 arrives while req0 is executing and must wait
        drive(2'b01, 8'h12, 8'h34, 3'b001, 8'h0, 8'h0, 3'd0);
        @(posedge clk); #1;
        drive(2'b10, 8'h0, 8'h0, 3'd0, 8'h0F, 8'h81, 3'b011);
        repeat (W + 3) @(posedge clk);
        #1 idle_cycles(W + 3);

        // Reset in the middle of EXEC aborts the operation
        drive(2'b01, 8'h44, 8'h22, 3'b001, 8'h0, 8'h0, 3'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        q.delete();
        free_at = 0; acc_edge = -1; m_last = 1'b1; m_cnt = '{0, 0};
        exp_d1 = '0; exp_d2 = '0; exp_sel = '0;
        drive(2'b00, 8'h0, 8'h0, 3'd0, 8'h0, 8'h0, 3'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle_cycles(1);
        drive(2'b10, 8'h0, 8'h0, 3'd0, 8'h09, 8'h06, 3'b001);
        @(posedge clk); #1 idle_cycles(W + 3);

        // Saturation run for requester 0
        drive(2'b01, 8'h01, 8'h02, 3'b011, 8'h0, 8'h0, 3'd0);
        repeat (300 * (W + 2) + 4) @(posedge clk);
        #1 idle_cycles(W + 3);

        // Random traffic, including withdrawn requests
        repeat (2000) begin
            drive(2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), 3'($urandom),
                  8'($urandom), 8'($urandom), 3'($urandom));
            @(posedge clk); #1;
        end
        idle_cycles(W + 4);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
